// File: rtl/pulse_to_level_if.sv
// Event-in / level-out bundle between a pulse source and pulse_to_level.
// Events are single-cycle strobes with no backpressure; status outputs are registered.
interface pulse_to_level_if;
  logic riseEvent;
  logic fallEvent;
  logic signalOut;
  logic busy;
  logic pending;
  logic dropped;

  modport master (
    output riseEvent, fallEvent,
    input  signalOut, busy, pending, dropped
  );

  modport slave (
    input  riseEvent, fallEvent,
    output signalOut, busy, pending, dropped
  );
endinterface

// File: rtl/pulse_to_level.sv
// Rebuilds a level from rise/fall pulses with min high/low times; one opposite event is buffered per hold.
// Latency: accepted event updates signalOut on the sampling edge; no backpressure, excess events are dropped.
module pulse_to_level #(
  parameter int MIN_HIGH = 4,
  parameter int MIN_LOW  = 4,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  pulse_to_level_if.slave    bus
);

  typedef enum logic [1:0] {
    LOW_IDLE  = 2'd0,
    HIGH_HOLD = 2'd1,
    HIGH_IDLE = 2'd2,
    LOW_HOLD  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LOAD_HIGH = CNT_W'(MIN_HIGH - 1);
  localparam logic [CNT_W-1:0] LOAD_LOW  = CNT_W'(MIN_LOW - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out;
  logic             r_busy;
  logic             r_pend;
  logic             r_drop;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_out_nxt;
  logic             w_pend_nxt;
  logic             w_drop_nxt;
  logic             w_pend_v;
  logic             w_rise;
  logic             w_fall;
  logic             w_both;

  // A simultaneous rise+fall is contradictory, so neither is acted on.
  assign w_both = bus.riseEvent & bus.fallEvent;
  assign w_rise = bus.riseEvent & ~bus.fallEvent;
  assign w_fall = bus.fallEvent & ~bus.riseEvent;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_out_nxt   = r_out;
    w_pend_nxt  = r_pend;
    w_drop_nxt  = w_both;
    w_pend_v    = r_pend;

    case (r_state)
      LOW_IDLE: begin
        if (w_rise) begin
          w_out_nxt   = 1'b1;
          w_cnt_nxt   = LOAD_HIGH;
          w_state_nxt = HIGH_HOLD;
        end
      end

      HIGH_IDLE: begin
        if (w_fall) begin
          w_out_nxt   = 1'b0;
          w_cnt_nxt   = LOAD_LOW;
          w_state_nxt = LOW_HOLD;
        end
      end

      HIGH_HOLD: begin
        if (w_fall) begin
          w_pend_v = 1'b1;
        end else if (w_rise && r_pend) begin
          // Latest request wins: a re-rise cancels the buffered fall.
          w_pend_v   = 1'b0;
          w_drop_nxt = 1'b1;
        end
        if (r_cnt == '0) begin
          w_pend_nxt = 1'b0;
          if (w_pend_v) begin
            w_out_nxt   = 1'b0;
            w_cnt_nxt   = LOAD_LOW;
            w_state_nxt = LOW_HOLD;
          end else begin
            w_state_nxt = HIGH_IDLE;
          end
        end else begin
          w_cnt_nxt  = r_cnt - 1'b1;
          w_pend_nxt = w_pend_v;
        end
      end

      LOW_HOLD: begin
        if (w_rise) begin
          w_pend_v = 1'b1;
        end else if (w_fall && r_pend) begin
          w_pend_v   = 1'b0;
          w_drop_nxt = 1'b1;
        end
        if (r_cnt == '0) begin
          w_pend_nxt = 1'b0;
          if (w_pend_v) begin
            w_out_nxt   = 1'b1;
            w_cnt_nxt   = LOAD_HIGH;
            w_state_nxt = HIGH_HOLD;
          end else begin
            w_state_nxt = LOW_IDLE;
          end
        end else begin
          w_cnt_nxt  = r_cnt - 1'b1;
          w_pend_nxt = w_pend_v;
        end
      end

      default: begin
        w_state_nxt = LOW_IDLE;
        w_out_nxt   = 1'b0;
        w_cnt_nxt   = '0;
        w_pend_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= LOW_IDLE;
      r_cnt   <= '0;
      r_out   <= 1'b0;
      r_busy  <= 1'b0;
      r_pend  <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_out   <= w_out_nxt;
      r_busy  <= (w_state_nxt == HIGH_HOLD) || (w_state_nxt == LOW_HOLD);
      r_pend  <= w_pend_nxt;
      r_drop  <= w_drop_nxt;
    end
  end

  assign bus.signalOut = r_out;
  assign bus.busy      = r_busy;
  assign bus.pending   = r_pend;
  assign bus.dropped   = r_drop;

endmodule

// File: tb/tb_pulse_to_level.sv
// Randomized and directed stimulus against a time-since-last-change reference model; a monitor scores every cycle.
module tb_pulse_to_level;
  localparam int MIN_HIGH = 4;
  localparam int MIN_LOW  = 3;
  localparam int CNT_W    = 8;
  localparam int AGE_SAT  = 1000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pulse_to_level_if bus();

  pulse_to_level #(
    .MIN_HIGH (MIN_HIGH),
    .MIN_LOW  (MIN_LOW),
    .CNT_W    (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic sig;
    logic busy;
    logic pend;
    logic drop;
    int   idx;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          n_push = 0;
  int          n_pop  = 0;
  logic [15:0] obs;

  // Reference model: current level, cycles it has been held, one buffered request.
  int m_level;
  int m_age;
  int m_pend;

  function automatic int min_of(input int lvl);
    return (lvl != 0) ? MIN_HIGH : MIN_LOW;
  endfunction

  task automatic model_reset();
    m_level = 0;
    m_age   = AGE_SAT;
    m_pend  = 0;
  endtask

  task automatic model_step(input logic r, input logic f, output exp_t e);
    int  mn;
    bit  held;
    bit  chg;
    bit  drop;
    bit  opp;
    bit  same;
    mn   = min_of(m_level);
    held = (m_age <= mn);
    chg  = 0;
    drop = 0;
    if (r && f) begin
      drop = 1;
    end else if (!held) begin
      if (m_level == 0 && r) chg = 1;
      if (m_level == 1 && f) chg = 1;
    end else begin
      opp  = (m_level != 0) ? f : r;
      same = (m_level != 0) ? r : f;
      if (opp) m_pend = 1;
      else if (same && m_pend != 0) begin
        m_pend = 0;
        drop   = 1;
      end
    end
    if (held && m_age == mn) begin
      if (m_pend != 0) chg = 1;
      m_pend = 0;
    end
    if (chg) begin
      m_level = 1 - m_level;
      m_age   = 1;
    end else if (m_age < AGE_SAT) begin
      m_age = m_age + 1;
    end
    e.sig  = (m_level != 0);
    e.busy = (m_age <= min_of(m_level));
    e.pend = (m_pend != 0);
    e.drop = drop;
    e.idx  = 0;
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %0b expected %0b", name, $time, act, req);
    end
  endtask

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_pop++;
      check1("signalOut", bus.signalOut, e.sig);
      check1("busy",      bus.busy,      e.busy);
      check1("pending",   bus.pending,   e.pend);
      check1("dropped",   bus.dropped,   e.drop);
      if (e.idx >= 0 && e.idx < 16) obs[e.idx] = bus.signalOut;
    end
  end

  task automatic step_cycle(input logic r, input logic f, input int idx);
    exp_t e;
    @(negedge clk);
    bus.riseEvent = r;
    bus.fallEvent = f;
    model_step(r, f, e);
    e.idx = idx;
    sb.push_back(e);
    n_push++;
  endtask

  // Asynchronous reset, checked before any clock edge can act on it.
  task automatic do_reset();
    @(negedge clk);
    bus.riseEvent = 1'b0;
    bus.fallEvent = 1'b0;
    #1 rst = 1'b1;
    #1;
    check1("rst_signalOut", bus.signalOut, 1'b0);
    check1("rst_busy",      bus.busy,      1'b0);
    check1("rst_pending",   bus.pending,   1'b0);
    check1("rst_dropped",   bus.dropped,   1'b0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic run_seq(input string name, input logic [15:0] rm, input logic [15:0] fm,
                         input int n, input logic [15:0] exp_sig);
    logic [15:0] mask;
    obs  = '0;
    mask = '0;
    for (int c = 0; c < n; c++) begin
      step_cycle(rm[c], fm[c], c + 1);
      mask[c + 1] = 1'b1;
    end
    @(posedge clk);
    #2;
    checks++;
    if ((obs & mask) !== (exp_sig & mask)) begin
      errors++;
      $display("FAIL %s waveform: got %h expected %h", name, obs & mask, exp_sig & mask);
    end
  endtask

  initial begin
    bus.riseEvent = 1'b0;
    bus.fallEvent = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Rise then fall, interrupted mid-hold with a fall pending.
    run_seq("midhold", 16'h0004, 16'h0008, 5, 16'h0038);
    do_reset();

    run_seq("rise_only",   16'h0004, 16'h0000, 12, 16'h1FF8);
    do_reset();
    run_seq("rise_fall",   16'h0004, 16'h0008, 12, 16'h0078);
    do_reset();
    run_seq("rise_fall_rise", 16'h0014, 16'h0008, 12, 16'h1FF8);
    do_reset();
    run_seq("simultaneous", 16'h0004, 16'h0004, 12, 16'h0000);
    do_reset();
    run_seq("redundant",   16'h0C10, 16'h0006, 12, 16'h1FE0);

    for (int k = 0; k < 6; k++) begin
      do_reset();
      for (int c = 0; c < 500; c++) begin
        step_cycle($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, -1);
      end
    end
    bus.riseEvent = 1'b0;
    bus.fallEvent = 1'b0;
    @(posedge clk);
    #2;

    checks++;
    if (n_pop != n_push) begin
      errors++;
      $display("FAIL scoreboard_drain: popped %0d expected %0d", n_pop, n_push);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pulse_to_level.md
Name: pulse_to_level

Overview:
- Converts single-cycle event pulses back into a registered level waveform. Inputs are riseEvent and fallEvent; the output is signalOut.
- Enforces minimum high and low times on signalOut. One opposite-polarity event that arrives during a hold window is buffered and applied when the hold expires.
- Sits after pulse-producing logic such as edge detectors, button debouncers and timer tick generators. It drives LEDs, enables and other downstream level consumers that must not see glitch-width pulses.

Parameters:
- MIN_HIGH, 4: minimum cycles signalOut stays high once raised. Legal range is 1 to 2^CNT_W.
- MIN_LOW, 4: minimum cycles signalOut stays low once lowered. Legal range is 1 to 2^CNT_W.
- CNT_W, 8: width of the hold counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- rst  input  1  asynchronous, active-high reset
- riseEvent  input  1  single-cycle request to drive signalOut high
- fallEvent  input  1  single-cycle request to drive signalOut low
- signalOut  output  1  registered level output
- busy  output  1  high while a minimum-time hold window is active
- pending  output  1  high while an event is buffered awaiting hold expiry
- dropped  output  1  registered one-cycle pulse: an event was discarded

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values, applied immediately on rst assertion: signalOut=0, busy=0, pending=0, dropped=0, counter=0, state=LOW_IDLE.
- Reset mid-hold drops the hold and any pending event silently; dropped is not asserted.
- State machine states:
  - LOW_IDLE: signalOut=0, low time satisfied.
  - HIGH_HOLD: signalOut=1, counting.
  - HIGH_IDLE: signalOut=1, high time satisfied.
  - LOW_HOLD: signalOut=0, counting.
- Latency: an accepted event sampled at edge n changes signalOut at edge n (visible in cycle n+1). Output is registered with no combinational path from inputs.
- LOW_IDLE:
  - riseEvent: set signalOut=1, load counter=MIN_HIGH-1, go to HIGH_HOLD.
  - fallEvent: redundant, ignored, dropped stays 0.
- HIGH_IDLE: mirror of LOW_IDLE. fallEvent sets signalOut=0, loads MIN_LOW-1 and goes to LOW_HOLD; riseEvent is ignored.
- HIGH_HOLD:
  - Counter decrements each cycle.
  - fallEvent sets pending=1.
  - riseEvent while pending=1 clears pending and pulses dropped (the latest request wins).
  - riseEvent while pending=0 is ignored.
  - When counter==0 at an edge: if pending, or fallEvent is present that same cycle, set signalOut=0, clear pending, load MIN_LOW-1 and go to LOW_HOLD. Otherwise go to HIGH_IDLE.
- LOW_HOLD: mirror of HIGH_HOLD with polarities swapped.
- Hold length:
  - A high pulse lasts exactly MIN_HIGH cycles when a fall is pending; otherwise it lasts until an accepted fallEvent.
  - With MIN_HIGH=1 the counter loads 0, so HIGH_HOLD lasts one cycle and an immediate fall is honoured on the next edge. The same applies to MIN_LOW.
- Simultaneous riseEvent and fallEvent in one cycle:
  - Both are discarded in every state, and dropped pulses for one cycle.
  - pending is unchanged.
  - The counter continues.
- busy = (state==HIGH_HOLD or LOW_HOLD), registered.
- pending is a single-entry buffer; it never exceeds one event.
- Counter arithmetic: unsigned CNT_W bits, loaded with MIN-1. It never decrements below 0 and never wraps.

Test Plan:
Bench parameters: MIN_HIGH=4, MIN_LOW=3.
- Reset applied mid-hold with pending=1 -> signalOut=0, busy=0, pending=0, dropped=0 immediately, before any clk edge.
- riseEvent at cycle 2 with no further events -> signalOut=1 from cycle 3; busy=1 for cycles 3..6; then HIGH_IDLE with busy=0 and signalOut held high.
- riseEvent at cycle 2, fallEvent at cycle 3 -> pending=1 cycles 4..6; signalOut high exactly cycles 3..6 and low from cycle 7; LOW_HOLD busy=1 cycles 7..9.
- riseEvent at cycle 2, fallEvent at cycle 3, riseEvent at cycle 4 -> dropped=1 in cycle 5, pending=0; signalOut stays high past cycle 6.
- riseEvent and fallEvent together at cycle 2 from LOW_IDLE -> signalOut stays 0, dropped=1 in cycle 3 only.
- Repeated fallEvent from LOW_IDLE, and repeated riseEvent in HIGH_IDLE -> no change on signalOut, dropped stays 0.
